// File: rtl/core_launch_controller.sv
// Host-side launch controller: starts a set of cores, watches their state buses for the
// return to idle, and reports completion mask, RUN cycle count and watchdog timeout.
module core_launch_controller #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned STATE_W = 6,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic [N_CORES-1:0]           core_mask,
    input  logic [N_CORES*STATE_W-1:0]   core_state,
    output logic [N_CORES-1:0]           start,
    output logic                         busy,
    output logic                         done,
    output logic [N_CORES-1:0]           done_mask,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N_CORES-1:0] run_mask;
    logic [N_CORES-1:0] started;
    logic [N_CORES-1:0] fin;
    logic [N_CORES-1:0] core_idle;
    logic [N_CORES-1:0] started_next;
    logic [N_CORES-1:0] fin_next;
    logic [CNT_W-1:0]   count_inc;
    logic               all_fin;
    logic               wd_fire;

    always_comb begin
        for (int unsigned i = 0; i < N_CORES; i++) begin
            core_idle[i] = (core_state[i*STATE_W +: STATE_W] == '0);
        end
    end

    // A core is complete only once it has been seen out of idle and then back at idle.
    always_comb begin
        started_next = started | (run_mask & ~core_idle);
        fin_next     = fin | (started & core_idle);
        all_fin      = &(fin_next | ~run_mask);
        count_inc    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
        wd_fire      = (TIMEOUT != 0) && (count_inc >= CNT_W'(TIMEOUT - 1));
    end

    // start is gated by reset and by the idle state so a finished core never refetches.
    always_comb begin
        start = '0;
        if (state == RUN && !reset) begin
            start = run_mask & ~fin & ~(started & core_idle);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go && core_mask != '0) state_next = RUN;
            RUN:     if (all_fin || wd_fire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            run_mask    <= '0;
            started     <= '0;
            fin         <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (core_mask != '0) begin
                            run_mask    <= core_mask;
                            started     <= '0;
                            fin         <= '0;
                            timeout     <= 1'b0;
                            cycle_count <= '0;
                        end else begin
                            done <= 1'b1;
                            fin  <= '0;
                        end
                    end
                end
                RUN: begin
                    started     <= started_next;
                    fin         <= fin_next;
                    cycle_count <= count_inc;
                    if (all_fin) begin
                        done <= 1'b1;
                    end else if (wd_fire) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done_mask = fin;

endmodule
